// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Purpose:
//   SPI mode-0 slave (MSB first) with a clk-domain parallel interface.
//   sck, cs_n and mosi are oversampled by clk. A frame runs from a cs_n fall
//   to a cs_n rise and may carry any number of back-to-back DATA_W-bit words.
//
// Optional feature:
//   SPI_SLAVE_OVERRUN_EN - when defined, a word completing while the previous
//   one is still unconsumed sets the sticky overrun flag, which ovr_clr
//   clears. When undefined, overrun is tied low and ovr_clr is ignored.
//
// Parameters:
//   DATA_W    frame width in bits (2..16)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   sck       SPI clock from master (asynchronous)
//   cs_n      SPI chip select, active low (asynchronous)
//   mosi      serial data from master (asynchronous)
//   miso      serial data to master
//   miso_oe   miso output enable, high while selected
//   tx_data   next word to transmit
//   tx_valid  tx_data holds a valid word
//   tx_ready  high in the cycle the tx shift register takes tx_data
//   rx_data   last received word
//   rx_valid  rx_data not yet consumed
//   rx_ready  consumer accepts rx_data
//   busy      frame in progress
//   overrun   sticky overrun flag
//   ovr_clr   clears overrun
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic sck_p0, sck_p1, sck_p2;
    logic cs_n_p0, cs_n_p1, cs_n_p2;
    logic mosi_p0, mosi_p1;

    // After reset the sync flops hold reset values rather than real samples.
    // A select is only honoured once cs_n has genuinely been seen high, so a
    // frame cut by reset is not resumed while cs_n stays low.
    logic [1:0] fill;
    logic       armed;

    logic sck_rise, sck_fall, cs_fall, cs_rise;
    logic load_en;
    logic [DATA_W-1:0] load_word;

    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              reload_pend;
    logic              word_done_p3;

    // ---- stage p0..p2: resynchronisers and edge detect ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            cs_n_p2 <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            fill    <= 2'd0;
            armed   <= 1'b0;
        end else begin
            sck_p0  <= sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            cs_n_p0 <= cs_n;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
            if (fill == 2'd3 && cs_n_p2) begin
                armed <= 1'b1;
            end
        end
    end

    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;
    assign cs_fall  = armed & ~cs_n_p1 & cs_n_p2;
    assign cs_rise  = cs_n_p1 & ~cs_n_p2;

    // ---- control FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        if (state == IDLE) begin
            if (cs_fall) begin
                state_nxt = ACTIVE;
                load_en   = 1'b1;
            end
        end else begin
            if (cs_rise) begin
                state_nxt = IDLE;
            end else if (sck_fall && bit_cnt == '0 && reload_pend) begin
                load_en = 1'b1;
            end
        end
    end

    assign load_word = tx_valid ? tx_data : {DATA_W{1'b1}};
    assign tx_ready  = load_en & tx_valid;
    assign busy      = (state == ACTIVE);
    assign miso_oe   = busy;
    assign miso      = busy ? tx_shift[DATA_W-1] : 1'b0;

    // ---- stage p3: shift registers and bit count ----
    // A cs_n rise wins over any sck edge seen in the same cycle and throws
    // away a partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            reload_pend  <= 1'b0;
            word_done_p3 <= 1'b0;
        end else begin
            word_done_p3 <= 1'b0;
            if (load_en) begin
                tx_shift    <= load_word;
                reload_pend <= 1'b0;
            end else if (state == ACTIVE && !cs_rise && sck_fall) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (state == ACTIVE) begin
                if (cs_rise) begin
                    bit_cnt     <= '0;
                    reload_pend <= 1'b0;
                end else if (sck_rise) begin
                    rx_shift <= {rx_shift[DATA_W-2:0], mosi_p1};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt      <= '0;
                        word_done_p3 <= 1'b1;
                        reload_pend  <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // ---- stage p4: received word handoff ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (word_done_p3) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            if (word_done_p3 && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int DATA_W = 8;
    localparam int HALF   = 4;   // sck half period in clk cycles (clk/8)

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sck = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready = 1'b1;
    logic              busy;
    logic              overrun;
    logic              ovr_clr = 1'b0;

    spi_slave #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // producer / monitor state
    logic [7:0] tx_q[$];
    int         txr_cnt = 0;
    int         rxv_rise = 0;
    logic [7:0] last_rx = '0;
    logic       rx_valid_prev = 1'b0;
    logic       txr_seen;

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    // tx producer: offers the queue head; a word leaves the queue once the
    // DUT has taken it, and tx_valid drops on the following cycle.
    always @(negedge clk) begin
        txr_seen = tx_ready;
        tx_valid = (tx_q.size() > 0);
        tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        if (txr_seen) begin
            txr_cnt++;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
        if (rx_valid && !rx_valid_prev) begin
            rxv_rise++;
            last_rx = rx_data;
        end
        rx_valid_prev = rx_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends the first nbits of w MSB first; captures miso just before each rise.
    task automatic spi_bits(input logic [7:0] w, input int nbits, output logic [7:0] m);
        m = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            repeat (HALF) @(negedge clk);
            m[7-i] = miso;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic do_frame(input int n, input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] ma, output logic [7:0] mb);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(a, 8, ma);
        mb = '0;
        if (n > 1) spi_bits(b, 8, mb);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] mosi_w;
        logic       tv;
        logic [7:0] tx_w;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_txr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] m0, m1;
        int txr0, rxr0;

        vecs[0] = '{8'h3C, 1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
        vecs[1] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'h5A, 8'hFF, 8'h5A, 1};
        vecs[3] = '{8'h81, 1'b1, 8'h7E, 8'h81, 8'h7E, 1};
        vecs[4] = '{8'h55, 1'b1, 8'h01, 8'h55, 8'h01, 1};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_miso",     miso,     0);
        check("rst_miso_oe",  miso_oe,  0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_data",  rx_data,  0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy",     busy,     0);
        check("rst_overrun",  overrun,  0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // single-word frames from the vector table
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].tv) tx_q.push_back(vecs[v].tx_w);
            repeat (2) @(negedge clk);
            txr0 = txr_cnt;
            rxr0 = rxv_rise;
            do_frame(1, vecs[v].mosi_w, 8'h00, m0, m1);
            check($sformatf("vec%0d_miso", v), m0, vecs[v].exp_miso);
            check($sformatf("vec%0d_rx_data", v), last_rx, vecs[v].exp_rx);
            check($sformatf("vec%0d_rx_rises", v), rxv_rise - rxr0, 1);
            check($sformatf("vec%0d_tx_ready_pulses", v), txr_cnt - txr0, vecs[v].exp_txr);
            check($sformatf("vec%0d_busy_after", v), busy, 0);
        end

        // back-to-back words in one select
        tx_q.push_back(8'h5A);
        tx_q.push_back(8'hC3);
        repeat (2) @(negedge clk);
        txr0 = txr_cnt;
        rxr0 = rxv_rise;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(8'h12, 8, m0);
        repeat (6) @(negedge clk);
        check("b2b_rx_first", last_rx, 8'h12);
        spi_bits(8'h34, 8, m1);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("b2b_rx_second", last_rx, 8'h34);
        check("b2b_rx_rises", rxv_rise - rxr0, 2);
        check("b2b_miso_first", m0, 8'h5A);
        check("b2b_miso_second", m1, 8'hC3);
        check("b2b_tx_ready_pulses", txr_cnt - txr0, 2);

        // select dropped after 5 bits, then a clean frame
        rxr0 = rxv_rise;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(8'hF0, 5, m0);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_rx_rises", rxv_rise - rxr0, 0);
        do_frame(1, 8'h81, 8'h00, m0, m1);
        check("after_abort_rx", last_rx, 8'h81);
        check("after_abort_rises", rxv_rise - rxr0, 1);

        // completion latency and hold while unconsumed
        rx_ready = 1'b0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(8'hC3, 7, m0);
        check("active_busy", busy, 1);
        check("active_miso_oe", miso_oe, 1);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_rx_valid_3cyc", rx_valid, 0);
        @(negedge clk);
        check("lat_rx_valid_4cyc", rx_valid, 1);
        check("lat_rx_data", rx_data, 8'hC3);
        sck = 1'b0;
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("hold_rx_valid", rx_valid, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("consume_rx_valid", rx_valid, 0);

        // overrun: two words, nobody consuming
        do_frame(2, 8'h11, 8'h22, m0, m1);
        check("ovr_flag", overrun, OVR_EXP);
        check("ovr_rx_data", rx_data, 8'h22);
        check("ovr_rx_valid", rx_valid, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", overrun, 0);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);

        // reset in the middle of a word
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(8'hAA, 4, m0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",     busy,     0);
        check("midrst_miso_oe",  miso_oe,  0);
        check("midrst_miso",     miso,     0);
        check("midrst_rx_data",  rx_data,  0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_tx_ready", tx_ready, 0);
        check("midrst_overrun",  overrun,  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("postrst_no_resume", busy, 0);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        tx_q.push_back(8'h3C);
        repeat (2) @(negedge clk);
        rxr0 = rxv_rise;
        do_frame(1, 8'h96, 8'h00, m0, m1);
        check("postrst_rx", last_rx, 8'h96);
        check("postrst_rises", rxv_rise - rxr0, 1);
        check("postrst_miso", m0, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL provide parameter: DATA_W, 8, frame width in bits (legal 2..16).
REQ-002 SHALL provide port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: sck  input  1  SPI serial clock from master, asynchronous to clk.
REQ-005 SHALL provide port: cs_n  input  1  SPI chip select from master, active low, asynchronous.
REQ-006 SHALL provide port: mosi  input  1  serial data from master, asynchronous.
REQ-007 SHALL provide port: miso  output  1  serial data to master.
REQ-008 SHALL provide port: miso_oe  output  1  miso output enable; 1 while selected.
REQ-009 SHALL provide port: tx_data  input  DATA_W  next word to transmit.
REQ-010 SHALL provide port: tx_valid  input  1  tx_data holds a valid word.
REQ-011 SHALL provide port: tx_ready  output  1  one-cycle pulse; tx shift register loaded this cycle.
REQ-012 SHALL provide port: rx_data  output  DATA_W  last received word.
REQ-013 SHALL provide port: rx_valid  output  1  rx_data unconsumed.
REQ-014 SHALL provide port: rx_ready  input  1  consumer accepts rx_data.
REQ-015 SHALL provide port: busy  output  1  frame in progress (state ACTIVE).
REQ-016 SHALL provide port: overrun  output  1  sticky overrun flag.
REQ-017 SHALL provide port: ovr_clr  input  1  clears overrun.

Function
REQ-018 SHALL resynchronize sck, cs_n, mosi via two flops each, plus a third sck/cs_n flop for edge detection; sync flops reset to sck=0, cs_n=1, mosi=0.
REQ-019 SHALL operate in SPI mode 0, MSB first: sample mosi on sck rising edge, shift miso on sck falling edge.
REQ-020 SHALL require sck high and low times of at least 3 clk periods each; slower sck is always supported.
REQ-021 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE on detected cs_n fall; ACTIVE->IDLE on detected cs_n rise.
REQ-022 SHALL, on IDLE->ACTIVE, load the tx shift register from tx_data if tx_valid, else all-ones, and pulse tx_ready only if tx_valid.
REQ-023 SHALL drive miso = tx shift register MSB and miso_oe=1 in ACTIVE; miso=0, miso_oe=0 in IDLE.
REQ-024 SHALL count sampled bits 0..DATA_W-1; the DATA_W-th rising edge copies the completed word to rx_data, sets rx_valid, and wraps the count to 0.
REQ-025 SHALL, on the first sck falling edge with the bit count at 0 after a completed word, reload the tx shift register per REQ-022 (back-to-back words within one select).
REQ-026 SHALL make a completed word visible in rx_data/rx_valid 4 clk cycles after the sck rising pin edge.
REQ-027 SHALL clear rx_valid on a cycle with rx_valid and rx_ready both 1; word completion in that same cycle keeps rx_valid=1 with new data.
REQ-028 SHALL, on cs_n rise mid-word, discard partial bits, reset the count to 0, and not assert rx_valid.
REQ-029 SHALL give a cs_n rise priority over an sck edge detected in the same cycle.
REQ-030 SHALL ignore sck edges while in IDLE.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE, count 0, shift registers 0, miso=0, miso_oe=0, tx_ready=0, rx_data=0, rx_valid=0, busy=0, overrun=0.
REQ-032 SHALL, on reset mid-frame, abandon the frame and resume only after a fresh cs_n fall post-reset.

Configuration
REQ-033 SHALL, with SPI_SLAVE_OVERRUN_EN defined, set overrun when a word completes while rx_valid=1 and rx_ready=0; rx_data is overwritten; overrun clears on ovr_clr (set wins on same-cycle conflict).
REQ-034 SHALL, without SPI_SLAVE_OVERRUN_EN, tie overrun to 0 and ignore ovr_clr; all other behaviour is identical.

Verification
REQ-035 SHALL cover: DATA_W=8, tx_data=0xA5 valid, master sends 0x3C at clk/8 -> miso shifts 0xA5, rx_data=0x3C, one rx_valid rise, one tx_ready pulse.
REQ-036 SHALL cover: tx_valid=0 at select -> miso returns 0xFF, no tx_ready pulse.
REQ-037 SHALL cover: two back-to-back words 0x12,0x34 under one select, rx_ready=1 -> rx_data 0x12 then 0x34, two tx_ready pulses.
REQ-038 SHALL cover: cs_n raised after 5 bits -> no rx_valid, busy=0, next frame 0x81 received correctly.
REQ-039 SHALL cover: rx_ready=0, two words (macro defined) -> overrun=1, rx_data=second word; ovr_clr -> overrun=0; macro undefined -> overrun stays 0.
REQ-040 SHALL cover: rst_n asserted mid-word -> all outputs at reset values immediately; next full frame after reset is received correctly.
